// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port sync RAM between fetch and data ports,
// data-priority with fetch anti-starvation and tagged in-order read returns.
module mem_arbiter #(
    parameter int XLEN       = 32,
    parameter int ADDR_W     = 12,
    parameter int READ_LAT   = 1,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    logic [SW-1:0]       starve_q, starve_d;
    logic [READ_LAT-1:0] vld_q, vld_d, own_q, own_d, live;
    logic [XLEN-1:0]     if_rdata_q, d_rdata_q;
    logic                d_win, f_win, issue_rd;

    always_comb begin
        d_win     = d_req && !(if_req && starve_q == SMAX);
        f_win     = if_req && !d_win;
        if_gnt    = f_win;
        d_gnt     = d_win;
        mem_en    = d_win || f_win;
        mem_we    = d_win && d_we;
        mem_be    = d_win ? d_be : 4'hF;
        mem_addr  = d_win ? d_addr : if_addr;
        mem_wdata = d_wdata;
        starve_d  = (f_win || !if_req) ? '0 : (starve_q == SMAX ? starve_q : starve_q + 1'b1);
        // flush kills fetch tags in every stage, including the one returning now
        live      = vld_q & ~(own_q & {READ_LAT{if_flush}});
        issue_rd  = (f_win && !if_flush) || (d_win && !d_we);
        vld_d     = (live << 1) | READ_LAT'(issue_rd);
        own_d     = (own_q << 1) | READ_LAT'(f_win);
        if_rvalid = live[READ_LAT-1] && own_q[READ_LAT-1];
        d_rvalid  = live[READ_LAT-1] && !own_q[READ_LAT-1];
        if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
        d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q   <= '0;
            vld_q      <= '0;
            own_q      <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
        end else begin
            starve_q   <= starve_d;
            vld_q      <= vld_d;
            own_q      <= own_d;
            if_rdata_q <= if_rdata;
            d_rdata_q  <= d_rdata;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a READ_LAT=1 and a READ_LAT=2 arbiter with identical
// stimulus; a reference model predicts grants and a scoreboard predicts returns.
module tb_mem_arbiter;
    typedef struct {
        logic        own;
        logic [31:0] data;
        int          due;
    } ent_t;

    logic        clk = 0, rst = 1;
    logic        if_req = 0, if_flush = 0, d_req = 0, d_we = 0;
    logic [11:0] if_addr = 0, d_addr = 0;
    logic [3:0]  d_be = 0;
    logic [31:0] d_wdata = 0;

    logic [1:0]  ig, ir, dg, dr, men, mwe;
    logic [31:0] ird [2];
    logic [31:0] drd [2];
    logic [3:0]  mbe [2];
    logic [11:0] maddr [2];
    logic [31:0] mwd [2];
    logic [31:0] rdl [2];
    logic [31:0] rp2;

    logic [31:0] ram [2][4096];
    logic        wrv [2][4096];
    logic [31:0] ref_mem [logic [11:0]];
    ent_t        sb [2][$];
    logic [31:0] h_if [2];
    logic [31:0] h_d [2];
    int          vec = 0, errs = 0, cyc = 0, st = 0;
    logic        exp_dw, exp_fw;
    logic [1:0]  last_ig;

    always #5 clk = ~clk;

    mem_arbiter #(.READ_LAT(1)) u0 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(ig[0]), .if_rvalid(ir[0]), .if_rdata(ird[0]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(dg[0]), .d_rvalid(dr[0]), .d_rdata(drd[0]),
        .mem_en(men[0]), .mem_we(mwe[0]), .mem_be(mbe[0]), .mem_addr(maddr[0]),
        .mem_wdata(mwd[0]), .mem_rdata(rdl[0]));

    mem_arbiter #(.READ_LAT(2)) u1 (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_gnt(ig[1]), .if_rvalid(ir[1]), .if_rdata(ird[1]),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(dg[1]), .d_rvalid(dr[1]), .d_rdata(drd[1]),
        .mem_en(men[1]), .mem_we(mwe[1]), .mem_be(mbe[1]), .mem_addr(maddr[1]),
        .mem_wdata(mwd[1]), .mem_rdata(rp2));

    function automatic logic [31:0] init_f(input logic [11:0] a);
        return a == 12'h010 ? 32'h00500093 : a == 12'h020 ? 32'h0 : {a, 8'h5A, a};
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = cur;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] ram_rd(input int k, input logic [11:0] a);
        return wrv[k][a] ? ram[k][a] : init_f(a);
    endfunction

    function automatic logic [31:0] ref_rd(input logic [11:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_f(a);
    endfunction

    // RAM models: DUT0 sees data one cycle after the access, DUT1 two cycles
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (men[k] && mwe[k]) begin
                ram[k][maddr[k]] <= merge(ram_rd(k, maddr[k]), mwd[k], mbe[k]);
                wrv[k][maddr[k]] <= 1'b1;
            end else if (men[k]) begin
                rdl[k] <= ram_rd(k, maddr[k]);
            end
        end
        rp2 <= rdl[1];
    end

    task automatic cmp(input string tag, input int k, input logic [31:0] obs,
                       input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s dut%0d cyc%0d: observed %h expected %h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            sb[k].delete();
            h_if[k] = '0;
            h_d[k]  = '0;
        end
        st = 0;
    endtask

    task automatic check();
        logic dw, fw;
        last_ig = ig;
        if (if_flush) begin
            for (int k = 0; k < 2; k++) begin
                ent_t t[$];
                t = sb[k];
                sb[k].delete();
                foreach (t[i]) if (!t[i].own) sb[k].push_back(t[i]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            logic ev_i, ev_d;
            ev_i = 0;
            ev_d = 0;
            if (sb[k].size() > 0 && sb[k][0].due == cyc) begin
                ent_t e;
                e = sb[k].pop_front();
                if (e.own) begin ev_i = 1; h_if[k] = e.data; end
                else begin ev_d = 1; h_d[k] = e.data; end
            end
            cmp("if_rvalid", k, 32'(ir[k]), 32'(ev_i));
            cmp("d_rvalid", k, 32'(dr[k]), 32'(ev_d));
            cmp("if_rdata", k, ird[k], h_if[k]);
            cmp("d_rdata", k, drd[k], h_d[k]);
        end
        dw = d_req && !(if_req && st == 3);
        fw = if_req && !dw;
        for (int k = 0; k < 2; k++) begin
            cmp("if_gnt", k, 32'(ig[k]), 32'(fw));
            cmp("d_gnt", k, 32'(dg[k]), 32'(dw));
            cmp("mem_en", k, 32'(men[k]), 32'(dw || fw));
            cmp("mem_we", k, 32'(mwe[k]), 32'(dw && d_we));
            if (dw || fw) begin
                cmp("mem_addr", k, 32'(maddr[k]), 32'(dw ? d_addr : if_addr));
                cmp("mem_be", k, 32'(mbe[k]), 32'(dw ? d_be : 4'hF));
            end
            if (dw && d_we) cmp("mem_wdata", k, mwd[k], d_wdata);
            if ((fw && !if_flush) || (dw && !d_we))
                sb[k].push_back('{fw, ref_rd(dw ? d_addr : if_addr), cyc + k + 1});
        end
        if (dw && d_we) ref_mem[d_addr] = merge(ref_rd(d_addr), d_wdata, d_be);
        st = (fw || !if_req) ? 0 : (st == 3 ? 3 : st + 1);
        exp_dw = dw;
        exp_fw = fw;
    endtask

    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [4:0] pat [2];
        int n;
        model_reset();
        #1 rst = 0;
        #2;
        for (int k = 0; k < 2; k++) begin
            cmp("rst_if_rvalid", k, 32'(ir[k]), 0);
            cmp("rst_d_rvalid", k, 32'(dr[k]), 0);
            cmp("rst_if_rdata", k, ird[k], 0);
            cmp("rst_d_rdata", k, drd[k], 0);
        end
        @(posedge clk);
        #1;
        step();
        rst = 1;
        idle(2);

        if_req = 1; if_addr = 12'h010;
        step();
        if_req = 0;
        idle(3);
        for (int k = 0; k < 2; k++) cmp("fetch_data", k, ird[k], 32'h00500093);

        d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 12'h020; d_wdata = 32'hAABBCCDD;
        step();
        d_we = 0;
        step();
        d_req = 0;
        idle(3);
        for (int k = 0; k < 2; k++) cmp("wr_then_rd", k, drd[k], 32'h0000CCDD);

        if_req = 1; if_addr = 12'h004; d_req = 1; d_we = 0; n = 0;
        for (int c = 0; c < 6; c++) begin
            d_req = (n < 5);
            d_addr = 12'h030 + 12'(n);
            step();
            if (c < 5) for (int k = 0; k < 2; k++) pat[k][c] = last_ig[k];
            if (exp_fw) if_req = 0;
            if (exp_dw) n++;
        end
        d_req = 0;
        for (int k = 0; k < 2; k++) cmp("starve_pattern", k, 32'(pat[k]), 32'b01000);
        idle(3);

        if_req = 1; if_addr = 12'h011;
        step();
        if_req = 0; d_req = 1; d_addr = 12'h005; if_flush = 1;
        step();
        d_req = 0; if_flush = 0;
        idle(4);

        if_req = 1; if_addr = 12'h012; if_flush = 1;
        step();
        if_req = 0; if_flush = 0;
        idle(3);

        for (int i = 0; i < 4; i++) begin
            if_req = (i % 2 == 0); d_req = (i % 2 == 1);
            if_addr = 12'h040 + 12'(i); d_addr = 12'h050 + 12'(i);
            step();
        end
        if_req = 0; d_req = 0;
        idle(3);

        for (int i = 0; i < 80; i++) begin
            if (!if_req && $urandom_range(1, 0) == 1) begin
                if_req = 1; if_addr = 12'($urandom_range(63, 0));
            end
            if (!d_req && $urandom_range(2, 0) != 0) begin
                d_req = 1; d_we = ($urandom_range(2, 0) == 0);
                d_be = 4'($urandom_range(15, 0)); d_addr = 12'($urandom_range(63, 0));
                d_wdata = $urandom;
            end
            if_flush = ($urandom_range(7, 0) == 0);
            step();
            if (exp_fw) if_req = 0;
            if (exp_dw) d_req = 0;
        end
        if_req = 0; d_req = 0; if_flush = 0;
        idle(4);

        if_req = 1; if_addr = 12'h013;
        step();
        if_req = 0; d_req = 1; d_we = 0; d_addr = 12'h014;
        step();
        d_req = 0;
        #1 rst = 0;
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("arst_if_rvalid", k, 32'(ir[k]), 0);
            cmp("arst_d_rvalid", k, 32'(dr[k]), 0);
            cmp("arst_if_rdata", k, ird[k], 0);
            cmp("arst_d_rdata", k, drd[k], 0);
        end
        model_reset();
        step();
        rst = 1;
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
